// File: rtl/gtp_tx_pkg.sv
// Shared constants, mode encodings and FSM state type for the GTP transmit framer.
package gtp_tx_pkg;

    localparam logic [7:0] K28_5       = 8'hBC;
    localparam logic [7:0] PCOMMA_MARK = 8'hAA;
    localparam logic [7:0] IDLE_MARK   = 8'h00;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_RR     = 2'd1;
    localparam logic [1:0] MODE_DEBUG  = 2'd2;
    localparam logic [1:0] MODE_RAMP   = 2'd3;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PCOMMA = 2'd2
    } tx_state_e;

endpackage

// File: rtl/gtp_txframer_rr_next.sv
// Combinational round-robin finder: lowest set mask bit strictly above cur,
// otherwise the lowest set bit overall (wrap).
module rr_next #(
    parameter int NCH = 16,
    parameter int IW  = 4
) (
    input  logic [NCH-1:0] mask,
    input  logic [IW-1:0]  cur,
    output logic [IW-1:0]  nxt,
    output logic           wrap,
    output logic           none
);

    logic [IW-1:0] above;
    logic [IW-1:0] low;
    logic          hit;

    // Descending scan so the last assignment is the lowest qualifying bit.
    always_comb begin
        above = '0;
        low   = '0;
        hit   = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low = IW'(i);
                if (IW'(i) > cur) begin
                    above = IW'(i);
                    hit   = 1'b1;
                end
            end
        end
    end

    assign none = ~|mask;
    assign nxt  = hit ? above : low;
    assign wrap = ~hit & ~none;

endmodule

// File: rtl/gtp_txframer.sv
// GTP lane transmit framer: start-up commas, periodic alignment commas and a
// four-mode data multiplexer over NCH packed ADC samples.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_INIT   | start-up commas {icnt, K28.5}, COMMA_INIT words
// ST_DATA   | data word per MODE, period counter running
// ST_PCOMMA | single periodic comma {AA, K28.5} with SYNC, pointers hold
module gtp_txframer
    import gtp_tx_pkg::*;
#(
    parameter int NCH          = 16,
    parameter int DW           = 12,
    parameter int TAGW         = 4,
    parameter int COMMA_INIT   = 10,
    parameter int COMMA_PERIOD = 1024
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NCH*DW-1:0] DIN,
    input  logic [1:0]        MODE,
    input  logic [TAGW-1:0]   CHSEL,
    input  logic [NCH-1:0]    CHMASK,
    input  logic [DW-1:0]     DEBUG,
    output logic [15:0]       TXDATA,
    output logic              TXCHARISK,
    output logic              SYNC,
    output logic              RR_WRAP
);

    localparam int            PW    = (COMMA_PERIOD > 1) ? $clog2(COMMA_PERIOD) : 1;
    localparam logic [PW-1:0] PLAST = PW'((COMMA_PERIOD > 1) ? COMMA_PERIOD - 1 : 0);
    localparam logic [7:0]    ILAST = 8'((COMMA_INIT > 0) ? COMMA_INIT - 1 : 0);

    tx_state_e     state, state_d;
    logic [7:0]    icnt, icnt_d;
    logic [PW-1:0] pcnt, pcnt_d;
    logic [TAGW-1:0] ptr, ptr_d;
    logic [DW-1:0] ramp, ramp_d;
    logic [1:0]    last_mode, last_mode_d;
    logic          dv, dv_d;

    logic [15:0]   txdata_d;
    logic          txk_d, sync_d, wrap_d;

    logic [TAGW-1:0] tag;
    logic [DW-1:0]   sample;
    logic [15:0]     data_word;
    logic            mode_entry;

    logic [TAGW-1:0] rr_cur_in, rr_nxt;
    logic            rr_wrap_raw, rr_none;
    logic [DW-1:0]   single_sample, rr_sample;

    // First data word after reset counts as a mode entry.
    assign mode_entry = ~dv | (last_mode != MODE);

    // Searching above the top index always wraps, yielding the lowest set bit.
    assign rr_cur_in = mode_entry ? TAGW'(NCH - 1) : ptr;

    rr_next #(
        .NCH (NCH),
        .IW  (TAGW)
    ) u_rr_next (
        .mask (CHMASK),
        .cur  (rr_cur_in),
        .nxt  (rr_nxt),
        .wrap (rr_wrap_raw),
        .none (rr_none)
    );

    // An out-of-range CHSEL matches no channel and leaves the sample at zero.
    always_comb begin
        single_sample = '0;
        rr_sample     = '0;
        for (int k = 0; k < NCH; k++) begin
            if (CHSEL == TAGW'(k))  single_sample = DIN[k*DW +: DW];
            if (rr_nxt == TAGW'(k)) rr_sample     = DIN[k*DW +: DW];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_INIT;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        icnt_d      = icnt;
        pcnt_d      = pcnt;
        ptr_d       = ptr;
        ramp_d      = ramp;
        last_mode_d = last_mode;
        dv_d        = dv;
        txdata_d    = {IDLE_MARK, K28_5};
        txk_d       = 1'b1;
        sync_d      = 1'b0;
        wrap_d      = 1'b0;
        tag         = '0;
        sample      = '0;
        data_word   = '0;

        case (state)
            ST_INIT: begin
                txdata_d = {icnt, K28_5};
                icnt_d   = icnt + 8'd1;
                if (icnt == ILAST) begin
                    icnt_d  = '0;
                    pcnt_d  = '0;
                    state_d = (COMMA_PERIOD == 1) ? ST_PCOMMA : ST_DATA;
                end
            end

            ST_PCOMMA: begin
                txdata_d = {PCOMMA_MARK, K28_5};
                sync_d   = 1'b1;
                pcnt_d   = '0;
                state_d  = (COMMA_PERIOD == 1) ? ST_PCOMMA : ST_DATA;
            end

            ST_DATA: begin
                dv_d        = 1'b1;
                last_mode_d = MODE;
                txk_d       = 1'b0;
                case (MODE)
                    MODE_SINGLE: begin
                        tag    = CHSEL;
                        sample = single_sample;
                    end
                    MODE_RR: begin
                        if (rr_none) begin
                            txk_d = 1'b1;
                        end else begin
                            tag    = rr_nxt;
                            sample = rr_sample;
                            ptr_d  = rr_nxt;
                            wrap_d = rr_wrap_raw & ~mode_entry;
                        end
                    end
                    MODE_DEBUG: begin
                        tag    = '1;
                        sample = DEBUG;
                    end
                    default: begin
                        tag    = CHSEL;
                        sample = mode_entry ? '0 : ramp;
                        ramp_d = sample + DW'(1);
                    end
                endcase

                data_word[DW-1:0]    = sample;
                data_word[DW +: TAGW] = tag;
                if (!txk_d) txdata_d = data_word;

                if (COMMA_PERIOD > 1) begin
                    pcnt_d = pcnt + PW'(1);
                    if (pcnt_d == PLAST) state_d = ST_PCOMMA;
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            icnt      <= '0;
            pcnt      <= '0;
            ptr       <= '0;
            ramp      <= '0;
            last_mode <= MODE_SINGLE;
            dv        <= 1'b0;
            TXDATA    <= {IDLE_MARK, K28_5};
            TXCHARISK <= 1'b1;
            SYNC      <= 1'b0;
            RR_WRAP   <= 1'b0;
        end else begin
            icnt      <= icnt_d;
            pcnt      <= pcnt_d;
            ptr       <= ptr_d;
            ramp      <= ramp_d;
            last_mode <= last_mode_d;
            dv        <= dv_d;
            TXDATA    <= txdata_d;
            TXCHARISK <= txk_d;
            SYNC      <= sync_d;
            RR_WRAP   <= wrap_d;
        end
    end

endmodule

// File: tb/tb_gtp_txframer.sv
// Bench for gtp_txframer: behavioural scoreboard model, a vector table and
// hand-written start-up, round-robin, comma, ramp and reset sequences.
module tb_gtp_txframer;

    localparam int NCH   = 16;
    localparam int DW    = 12;
    localparam int TAGW  = 4;
    localparam int CINIT = 10;
    localparam int CPER  = 16;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b1;
    logic [NCH*DW-1:0] DIN = '0;
    logic [1:0]        MODE = 2'd0;
    logic [TAGW-1:0]   CHSEL = '0;
    logic [NCH-1:0]    CHMASK = '0;
    logic [DW-1:0]     DEBUG = '0;
    logic [15:0]       TXDATA;
    logic              TXCHARISK, SYNC, RR_WRAP;

    gtp_txframer #(
        .NCH(NCH), .DW(DW), .TAGW(TAGW), .COMMA_INIT(CINIT), .COMMA_PERIOD(CPER)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DIN(DIN), .MODE(MODE), .CHSEL(CHSEL),
        .CHMASK(CHMASK), .DEBUG(DEBUG), .TXDATA(TXDATA), .TXCHARISK(TXCHARISK),
        .SYNC(SYNC), .RR_WRAP(RR_WRAP)
    );

    always #4 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] data;
        logic        k;
        logic        sync;
        logic        wrap;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  chsel;
        logic [15:0] chmask;
        logic [11:0] debug;
        int          ncyc;
        logic [16:0] first_exp;
    } vec_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int         m_icnt, m_pc, m_ptr;
    bit         m_dv;
    logic [1:0] m_last;
    logic [11:0] m_ramp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic model_reset();
        m_icnt = 0; m_pc = 0; m_ptr = 0; m_dv = 0; m_last = 2'd0; m_ramp = '0;
    endtask

    // Expected output for the edge about to happen, from the inputs driven now.
    task automatic model(output exp_t e);
        logic [11:0] s;
        logic [3:0]  tag;
        int          c;
        bit          found, entry;
        e = '{data: 16'h00BC, k: 1'b1, sync: 1'b0, wrap: 1'b0};
        s = '0; tag = '0; c = 0;
        if (m_icnt < CINIT) begin
            e.data = {8'(m_icnt), 8'hBC};
            m_icnt++;
        end else if (m_pc == CPER - 1) begin
            e.data = 16'hAABC;
            e.sync = 1'b1;
            m_pc   = 0;
        end else begin
            m_pc++;
            entry  = !m_dv || (m_last != MODE);
            m_dv   = 1'b1;
            m_last = MODE;
            e.k    = 1'b0;
            case (MODE)
                2'd0: begin tag = CHSEL; s = DIN[CHSEL*DW +: DW]; end
                2'd1: begin
                    if (CHMASK == '0) begin
                        e.k = 1'b1;
                    end else begin
                        found = 1'b0;
                        if (!entry)
                            for (int i = m_ptr + 1; i < NCH && !found; i++)
                                if (CHMASK[i]) begin c = i; found = 1'b1; end
                        if (!found) begin
                            for (int i = NCH - 1; i >= 0; i--) if (CHMASK[i]) c = i;
                            e.wrap = !entry;
                        end
                        m_ptr = c;
                        tag   = 4'(c);
                        s     = DIN[c*DW +: DW];
                    end
                end
                2'd2: begin tag = 4'hF; s = DEBUG; end
                default: begin
                    if (entry) m_ramp = '0;
                    tag    = CHSEL;
                    s      = m_ramp;
                    m_ramp = m_ramp + 12'd1;
                end
            endcase
            if (!e.k) e.data = {tag, s};
        end
    endtask

    task automatic cycle();
        exp_t e, a, x;
        model(e);
        sbq.push_back(e);
        @(posedge CLK);
        #1;
        a = {TXDATA, TXCHARISK, SYNC, RR_WRAP};
        x = sbq.pop_front();
        chk("scoreboard {data,k,sync,wrap}", 32'(a), 32'(x));
    endtask

    task automatic fill_pattern();
        for (int k = 0; k < NCH; k++) DIN[k*DW +: DW] = {4'(k), 8'hA5};
    endtask

    task automatic fill_random();
        for (int k = 0; k < NCH; k++) DIN[k*DW +: DW] = 12'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[11];
        bit         got, seen, follow;
        int         ntag, nsync, last_sync, prev_tag, nw;
        logic [3:0] tags[4];
        bit         wraps[4];

        vt[0]  = '{2'd0, 4'd0,  16'h0000, 12'h000, 20, {16'h00A5, 1'b0}};
        vt[1]  = '{2'd0, 4'd15, 16'h0000, 12'h000, 20, {16'hFFA5, 1'b0}};
        vt[2]  = '{2'd2, 4'd0,  16'h0000, 12'h123, 10, {16'hF123, 1'b0}};
        vt[3]  = '{2'd1, 4'd0,  16'h8011, 12'h000, 24, {16'h00A5, 1'b0}};
        vt[4]  = '{2'd0, 4'd7,  16'h8011, 12'h000, 10, {16'h77A5, 1'b0}};
        vt[5]  = '{2'd1, 4'd0,  16'h0100, 12'h000, 12, {16'h88A5, 1'b0}};
        vt[6]  = '{2'd2, 4'd0,  16'h0100, 12'hFFF, 8,  {16'hFFFF, 1'b0}};
        vt[7]  = '{2'd1, 4'd0,  16'h0000, 12'h000, 6,  {16'h00BC, 1'b1}};
        vt[8]  = '{2'd3, 4'd9,  16'h0000, 12'h000, 20, {16'h9000, 1'b0}};
        vt[9]  = '{2'd1, 4'd0,  16'hFFFF, 12'h000, 40, {16'h00A5, 1'b0}};
        vt[10] = '{2'd0, 4'd3,  16'hFFFF, 12'h000, 10, {16'h33A5, 1'b0}};

        model_reset();
        #1 RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_outputs", {TXDATA, TXCHARISK, SYNC, RR_WRAP}, {16'h00BC, 3'b100});

        // start-up commas, then single channel 5 with one-clock latency
        MODE = 2'd0; CHSEL = 4'd5; DIN[5*DW +: DW] = 12'h000;
        RESET_N = 1'b1;
        for (int i = 0; i < CINIT; i++) begin
            cycle();
            chk($sformatf("init_word%0d", i), {TXDATA, TXCHARISK}, {8'(i), 8'hBC, 1'b1});
        end
        DIN[5*DW +: DW] = 12'hABC;
        cycle();
        chk("single_ch5", {TXDATA, TXCHARISK}, {16'h5ABC, 1'b0});

        for (int v = 0; v < 11; v++) begin
            MODE = vt[v].mode; CHSEL = vt[v].chsel; CHMASK = vt[v].chmask; DEBUG = vt[v].debug;
            fill_pattern();
            got = 1'b0;
            for (int n = 0; n < vt[v].ncyc; n++) begin
                cycle();
                if (!got && !SYNC) begin
                    got = 1'b1;
                    chk($sformatf("vec%0d_first", v), {TXDATA, TXCHARISK}, vt[v].first_exp);
                end
                fill_random();
            end
        end

        // round-robin 0,4,15,0 with wrap on the 15->0 word
        MODE = 2'd1; CHMASK = 16'h8011; ntag = 0;
        for (int n = 0; n < 12 && ntag < 4; n++) begin
            cycle();
            if (!TXCHARISK) begin
                tags[ntag] = TXDATA[15:12]; wraps[ntag] = RR_WRAP; ntag++;
            end
        end
        chk("rr_count", ntag, 4);
        chk("rr_tags", {tags[0], tags[1], tags[2], tags[3]}, 16'h04F0);
        chk("rr_wraps", {wraps[0], wraps[1], wraps[2], wraps[3]}, 4'b0001);

        CHMASK = 16'h0000;
        cycle();
        if (SYNC) cycle();
        chk("rr_idle", {TXDATA, TXCHARISK, SYNC}, {16'h00BC, 2'b10});

        // periodic commas every CPER clocks, sequence continues across them
        CHMASK = 16'h000F; prev_tag = -1; last_sync = -1; follow = 1'b0; nsync = 0;
        for (int n = 0; n < 50; n++) begin
            cycle();
            fill_random();
            if (SYNC) begin
                chk("pc_word", {TXDATA, TXCHARISK}, {16'hAABC, 1'b1});
                if (last_sync >= 0) chk("pc_spacing", n - last_sync, CPER);
                last_sync = n; follow = 1'b1; nsync++;
            end else if (!TXCHARISK) begin
                if (follow && prev_tag >= 0)
                    chk("pc_follow", TXDATA[15:12], 4'((prev_tag + 1) % 4));
                follow = 1'b0;
                prev_tag = int'(TXDATA[15:12]);
            end
        end
        chk("pc_seen", nsync >= 3, 1);

        // mode change coinciding with a comma lands on the next data word
        for (int n = 0; n < CPER && m_pc != CPER - 1; n++) cycle();
        MODE = 2'd2; DEBUG = 12'h5A5;
        cycle();
        chk("mc_comma", {TXDATA, SYNC}, {16'hAABC, 1'b1});
        cycle();
        chk("mc_debug", {TXDATA, TXCHARISK}, {16'hF5A5, 1'b0});

        // ramp through a full wrap under tag 2
        MODE = 2'd3; CHSEL = 4'd2; nw = 0;
        for (int c = 0; c < 4600 && nw < 4098; c++) begin
            cycle();
            if (!TXCHARISK) begin
                if (nw == 0)    chk("ramp_first", TXDATA, 16'h2000);
                if (nw == 1)    chk("ramp_second", TXDATA, 16'h2001);
                if (nw == 4095) chk("ramp_top", TXDATA, 16'h2FFF);
                if (nw == 4096) chk("ramp_wrap", TXDATA, 16'h2000);
                nw++;
            end
        end
        chk("ramp_len", nw, 4098);

        // reset mid-stream in round-robin, pointer restarts at lowest set bit
        MODE = 2'd1; CHMASK = 16'h0070; seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            cycle();
            if (!TXCHARISK && TXDATA[15:12] == 4'd4) seen = 1'b1;
        end
        chk("rst_pre_ptr4", seen, 1);
        RESET_N = 1'b0;
        #1;
        chk("rst_async", {TXDATA, TXCHARISK, SYNC, RR_WRAP}, {16'h00BC, 3'b100});
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_hold", {TXDATA, TXCHARISK, SYNC, RR_WRAP}, {16'h00BC, 3'b100});
        RESET_N = 1'b1;
        for (int i = 0; i < CINIT; i++) begin
            cycle();
            chk($sformatf("reinit_word%0d", i), {TXDATA, TXCHARISK}, {8'(i), 8'hBC, 1'b1});
        end
        cycle();
        chk("rst_ptr_lowest", {TXDATA[15:12], TXCHARISK}, {4'h4, 1'b0});
        for (int n = 0; n < 6; n++) begin
            fill_random();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
